// File: rtl/gpu_pkg.sv
// Shared types, default widths and helpers for the kernel block dispatcher.
package gpu_pkg;

  localparam int unsigned DefBlockIdWidth = 8;
  localparam int unsigned DefCycleWidth   = 32;
  localparam int unsigned MaxCores        = 16;

  typedef enum logic [1:0] {
    StIdle,
    StDispatch,
    StDrain,
    StDone
  } dispatch_state_t;

  function automatic logic [4:0] popcount(input logic [MaxCores-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < MaxCores; i++) begin
      n = n + {4'b0000, v[i]};
    end
    return n;
  endfunction

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/core_select.sv
// Combinational free-core picker: lowest-index by default, round-robin from a
// pointer when BLOCK_DISPATCH_RR_EN is defined.
module core_select import gpu_pkg::*; #(
  parameter int unsigned NUM_CORES = 2
) (
  input  logic [NUM_CORES-1:0]            free_i,
`ifdef BLOCK_DISPATCH_RR_EN
  input  logic [ptr_width(NUM_CORES)-1:0] ptr_i,
`endif
  output logic                            found_o,
  output logic [NUM_CORES-1:0]            grant_o
);

  logic [NUM_CORES-1:0] req;

`ifdef BLOCK_DISPATCH_RR_EN
  logic [NUM_CORES-1:0] upper;

  // Prefer free cores at or above the pointer; wrap to the bottom otherwise.
  always_comb begin
    upper = free_i & ({NUM_CORES{1'b1}} << ptr_i);
    req   = (|upper) ? upper : free_i;
  end
`else
  always_comb begin
    req = free_i;
  end
`endif

  // Isolate the lowest set bit of the request vector.
  always_comb begin
    found_o = |free_i;
    grant_o = req & (~req + NUM_CORES'(1));
  end

endmodule

// File: rtl/block_dispatcher.sv
// Kernel launch controller: issues thread blocks to free cores and tracks completion.
// Optional round-robin core selection under BLOCK_DISPATCH_RR_EN.
module block_dispatcher import gpu_pkg::*; #(
  parameter int unsigned NUM_CORES      = 2,
  parameter int unsigned BLOCK_ID_WIDTH = DefBlockIdWidth,
  parameter int unsigned CYCLE_WIDTH    = DefCycleWidth
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [BLOCK_ID_WIDTH-1:0]           num_blocks,
  output logic                                busy,
  output logic                                done,
  output logic [NUM_CORES-1:0]                core_start,
  output logic [NUM_CORES*BLOCK_ID_WIDTH-1:0] core_block_id,
  input  logic [NUM_CORES-1:0]                core_done,
  output logic [BLOCK_ID_WIDTH-1:0]           blocks_dispatched,
  output logic [BLOCK_ID_WIDTH-1:0]           blocks_completed,
  output logic [CYCLE_WIDTH-1:0]              kernel_cycles
);

  localparam int unsigned BW = BLOCK_ID_WIDTH;

  dispatch_state_t state_q, state_d;
  logic [BW-1:0] num_q, num_d;
  logic [BW-1:0] disp_q, disp_d;
  logic [BW-1:0] comp_q, comp_d;
  logic [CYCLE_WIDTH-1:0] cycles_q, cycles_d;
  logic [NUM_CORES-1:0] free_q, free_d;
  logic [NUM_CORES-1:0][BW-1:0] ids_q, ids_d;
  logic [NUM_CORES-1:0] grant, done_valid;
  logic found;

`ifdef BLOCK_DISPATCH_RR_EN
  localparam int unsigned PtrW = ptr_width(NUM_CORES);
  logic [PtrW-1:0] ptr_q, ptr_d;
`endif

  core_select #(
    .NUM_CORES(NUM_CORES)
  ) u_core_select (
    .free_i (free_q),
`ifdef BLOCK_DISPATCH_RR_EN
    .ptr_i  (ptr_q),
`endif
    .found_o(found),
    .grant_o(grant)
  );

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    disp_d     = disp_q;
    comp_d     = comp_q;
    cycles_d   = cycles_q;
    free_d     = free_q;
    ids_d      = ids_q;
    core_start = '0;
`ifdef BLOCK_DISPATCH_RR_EN
    ptr_d      = ptr_q;
`endif
    // Completions from cores we never dispatched to are dropped.
    done_valid = core_done & ~free_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StDispatch;
          num_d    = num_blocks;
          disp_d   = '0;
          comp_d   = '0;
          cycles_d = '0;
          free_d   = '1;
`ifdef BLOCK_DISPATCH_RR_EN
          ptr_d    = '0;
`endif
        end
      end
      StDispatch, StDrain: begin
        comp_d = comp_q + BW'(popcount(MaxCores'(done_valid)));
        free_d = free_q | done_valid;
        if (cycles_q != '1) cycles_d = cycles_q + CYCLE_WIDTH'(1);
        if (state_q == StDispatch) begin
          if (disp_q != num_q && found) begin
            core_start = grant;
            free_d     = free_d & ~grant;
            disp_d     = disp_q + BW'(1);
            for (int c = 0; c < NUM_CORES; c++) begin
              if (grant[c]) begin
                ids_d[c] = disp_q;
`ifdef BLOCK_DISPATCH_RR_EN
                ptr_d    = PtrW'((c + 1) % NUM_CORES);
`endif
              end
            end
          end
          if (disp_d == num_q) state_d = StDrain;
        end else if (comp_d == num_q) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      num_q    <= '0;
      disp_q   <= '0;
      comp_q   <= '0;
      cycles_q <= '0;
      free_q   <= '1;
      ids_q    <= '0;
`ifdef BLOCK_DISPATCH_RR_EN
      ptr_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      disp_q   <= disp_d;
      comp_q   <= comp_d;
      cycles_q <= cycles_d;
      free_q   <= free_d;
      ids_q    <= ids_d;
`ifdef BLOCK_DISPATCH_RR_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  // ids_d already carries the fresh id for the core being started this cycle.
  always_comb begin
    busy              = (state_q == StDispatch) || (state_q == StDrain);
    done              = (state_q == StDone);
    core_block_id     = ids_d;
    blocks_dispatched = disp_q;
    blocks_completed  = comp_q;
    kernel_cycles     = cycles_q;
  end

endmodule

// File: tb/tb_block_dispatcher.sv
// Directed self-checking bench for block_dispatcher (2 cores; 4-core round-robin
// instance added when BLOCK_DISPATCH_RR_EN is defined).
module tb_block_dispatcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  num_blocks;
  logic        busy, done;
  logic [1:0]  core_start;
  logic [15:0] core_block_id;
  logic [1:0]  core_done;
  logic [7:0]  blocks_dispatched, blocks_completed;
  logic [31:0] kernel_cycles;

  int cmp = 0;
  int errs = 0;

  int got_id[$];
  int got_core[$];
  int done_cyc;
  logic c1_done;
  int c1_bc, c1_kc;

  always #5 clk = ~clk;

  block_dispatcher #(
    .NUM_CORES(2),
    .BLOCK_ID_WIDTH(8),
    .CYCLE_WIDTH(32)
  ) u_dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .num_blocks       (num_blocks),
    .busy             (busy),
    .done             (done),
    .core_start       (core_start),
    .core_block_id    (core_block_id),
    .core_done        (core_done),
    .blocks_dispatched(blocks_dispatched),
    .blocks_completed (blocks_completed),
    .kernel_cycles    (kernel_cycles)
  );

`ifdef BLOCK_DISPATCH_RR_EN
  logic        r_start;
  logic [7:0]  r_num;
  logic        r_busy, r_done;
  logic [3:0]  r_core_start, r_core_done;
  logic [31:0] r_core_block_id;
  logic [7:0]  r_bd, r_bc;
  logic [31:0] r_kc;

  block_dispatcher #(
    .NUM_CORES(4),
    .BLOCK_ID_WIDTH(8),
    .CYCLE_WIDTH(32)
  ) u_rr (
    .clk              (clk),
    .reset            (reset),
    .start            (r_start),
    .num_blocks       (r_num),
    .busy             (r_busy),
    .done             (r_done),
    .core_start       (r_core_start),
    .core_block_id    (r_core_block_id),
    .core_done        (r_core_done),
    .blocks_dispatched(r_bd),
    .blocks_completed (r_bc),
    .kernel_cycles    (r_kc)
  );
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 drives start; each core answers core_done lat cycles after its core_start.
  task automatic run_kernel(input int n, input int lat);
    int due[2];
    due[0] = -1;
    due[1] = -1;
    got_id.delete();
    got_core.delete();
    done_cyc = -1;
    for (int cyc = 0; cyc < 200 && done_cyc < 0; cyc++) begin
      start      = (cyc == 0);
      num_blocks = n[7:0];
      for (int c = 0; c < 2; c++) core_done[c] = (due[c] == cyc);
      if (done && cyc > 0) done_cyc = cyc;
      for (int c = 0; c < 2; c++) begin
        if (core_start[c]) begin
          got_core.push_back(c);
          got_id.push_back(int'(core_block_id[c*8 +: 8]));
          due[c] = cyc + lat;
        end
      end
      if (cyc == 1) begin
        c1_done = done;
        c1_bc   = int'(blocks_completed);
        c1_kc   = int'(kernel_cycles);
      end
      tick();
    end
    start     = 1'b0;
    core_done = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    cmp++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %0b want 0", busy); end
    cmp++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done: got %0b want 0", done); end
    cmp++; if (core_start !== 2'b00) begin errs++; $display("FAIL reset_core_start: got %b want 00", core_start); end
    cmp++; if (core_block_id !== 16'h0) begin errs++; $display("FAIL reset_block_id: got %h want 0", core_block_id); end
    cmp++; if (blocks_dispatched !== 8'd0) begin errs++; $display("FAIL reset_bd: got %0d want 0", blocks_dispatched); end
    cmp++; if (blocks_completed !== 8'd0) begin errs++; $display("FAIL reset_bc: got %0d want 0", blocks_completed); end
    cmp++; if (kernel_cycles !== 32'd0) begin errs++; $display("FAIL reset_kc: got %0d want 0", kernel_cycles); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_five_blocks();
    run_kernel(5, 3);
    cmp++; if (got_id.size() != 5) begin errs++; $display("FAIL five_count: got %0d want 5", got_id.size()); end
    for (int i = 0; i < 5 && i < got_id.size(); i++) begin
      cmp++; if (got_id[i] != i) begin errs++; $display("FAIL five_id[%0d]: got %0d want %0d", i, got_id[i], i); end
      cmp++; if (got_core[i] != i % 2) begin errs++; $display("FAIL five_core[%0d]: got %0d want %0d", i, got_core[i], i % 2); end
    end
    cmp++; if (done_cyc != 13) begin errs++; $display("FAIL five_done_cycle: got %0d want 13", done_cyc); end
    cmp++; if (blocks_dispatched !== 8'd5) begin errs++; $display("FAIL five_bd: got %0d want 5", blocks_dispatched); end
    cmp++; if (blocks_completed !== 8'd5) begin errs++; $display("FAIL five_bc: got %0d want 5", blocks_completed); end
    cmp++; if (kernel_cycles !== 32'd12) begin errs++; $display("FAIL five_kc: got %0d want 12", kernel_cycles); end
    cmp++; if (busy !== 1'b0 || done !== 1'b1) begin errs++; $display("FAIL five_status: got busy=%0b done=%0b want 0/1", busy, done); end
  endtask

  task automatic test_zero_blocks();
    run_kernel(0, 3);
    cmp++; if (got_core.size() != 0) begin errs++; $display("FAIL zero_starts: got %0d want 0", got_core.size()); end
    cmp++; if (c1_done !== 1'b0) begin errs++; $display("FAIL zero_done_drop: got %0b want 0", c1_done); end
    cmp++; if (done_cyc != 3) begin errs++; $display("FAIL zero_done_cycle: got %0d want 3", done_cyc); end
    cmp++; if (kernel_cycles !== 32'd2) begin errs++; $display("FAIL zero_kc: got %0d want 2", kernel_cycles); end
  endtask

  task automatic test_simultaneous_done();
    start = 1'b1; num_blocks = 8'd4;
    tick();
    start = 1'b0;
    cmp++; if (core_start !== 2'b01 || core_block_id[7:0] !== 8'd0) begin errs++; $display("FAIL sim_c1: got %b/%0d want 01/0", core_start, core_block_id[7:0]); end
    tick();
    cmp++; if (core_start !== 2'b10 || core_block_id[15:8] !== 8'd1) begin errs++; $display("FAIL sim_c2: got %b/%0d want 10/1", core_start, core_block_id[15:8]); end
    tick();
    cmp++; if (core_start !== 2'b00) begin errs++; $display("FAIL sim_c3: got %b want 00", core_start); end
    core_done = 2'b11;
    tick();
    core_done = 2'b00;
    cmp++; if (blocks_completed !== 8'd2) begin errs++; $display("FAIL sim_bc2: got %0d want 2", blocks_completed); end
    cmp++; if (core_start !== 2'b01 || core_block_id[7:0] !== 8'd2) begin errs++; $display("FAIL sim_c4: got %b/%0d want 01/2", core_start, core_block_id[7:0]); end
    tick();
    cmp++; if (core_start !== 2'b10 || core_block_id[15:8] !== 8'd3) begin errs++; $display("FAIL sim_c5: got %b/%0d want 10/3", core_start, core_block_id[15:8]); end
    tick();
    core_done = 2'b11;
    tick();
    core_done = 2'b00;
    cmp++; if (done !== 1'b1 || blocks_completed !== 8'd4) begin errs++; $display("FAIL sim_end: got done=%0b bc=%0d want 1/4", done, blocks_completed); end
  endtask

  task automatic test_spurious_done();
    start = 1'b1; num_blocks = 8'd1;
    tick();
    start = 1'b0;
    cmp++; if (core_start !== 2'b01) begin errs++; $display("FAIL spur_start: got %b want 01", core_start); end
    tick();
    core_done = 2'b10;
    tick();
    core_done = 2'b00;
    cmp++; if (blocks_completed !== 8'd0 || done !== 1'b0) begin errs++; $display("FAIL spur_ignored: got bc=%0d done=%0b want 0/0", blocks_completed, done); end
    core_done = 2'b01;
    tick();
    core_done = 2'b00;
    cmp++; if (blocks_completed !== 8'd1 || done !== 1'b1) begin errs++; $display("FAIL spur_finish: got bc=%0d done=%0b want 1/1", blocks_completed, done); end
  endtask

  task automatic test_start_in_drain();
    start = 1'b1; num_blocks = 8'd2;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; num_blocks = 8'd7;
    tick();
    start = 1'b0;
    cmp++; if (busy !== 1'b1 || blocks_dispatched !== 8'd2 || core_start !== 2'b00) begin
      errs++; $display("FAIL drain_start_ignored: got busy=%0b bd=%0d cs=%b want 1/2/00", busy, blocks_dispatched, core_start); end
    core_done = 2'b11;
    tick();
    core_done = 2'b00;
    cmp++; if (done !== 1'b1 || blocks_completed !== 8'd2) begin errs++; $display("FAIL drain_finish: got done=%0b bc=%0d want 1/2", done, blocks_completed); end
    cmp++; if (kernel_cycles !== 32'd4) begin errs++; $display("FAIL drain_kc: got %0d want 4", kernel_cycles); end
    run_kernel(3, 2);
    cmp++; if (c1_done !== 1'b0 || c1_bc != 0 || c1_kc != 0) begin errs++; $display("FAIL restart_clear: got done=%0b bc=%0d kc=%0d want 0/0/0", c1_done, c1_bc, c1_kc); end
    cmp++; if (got_id.size() != 3) begin errs++; $display("FAIL restart_count: got %0d want 3", got_id.size()); end
    for (int i = 0; i < 3 && i < got_id.size(); i++) begin
      cmp++; if (got_id[i] != i) begin errs++; $display("FAIL restart_id[%0d]: got %0d want %0d", i, got_id[i], i); end
    end
    cmp++; if (done_cyc != 7) begin errs++; $display("FAIL restart_done_cycle: got %0d want 7", done_cyc); end
    cmp++; if (kernel_cycles !== 32'd6 || blocks_completed !== 8'd3) begin errs++; $display("FAIL restart_end: got kc=%0d bc=%0d want 6/3", kernel_cycles, blocks_completed); end
  endtask

  task automatic test_reset_mid_kernel();
    start = 1'b1; num_blocks = 8'd5;
    tick();
    start = 1'b0;
    tick();
    tick();
    cmp++; if (busy !== 1'b1 || blocks_dispatched !== 8'd2) begin errs++; $display("FAIL midrst_pre: got busy=%0b bd=%0d want 1/2", busy, blocks_dispatched); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cmp++; if (busy !== 1'b0 || done !== 1'b0 || core_start !== 2'b00 || core_block_id !== 16'h0) begin
      errs++; $display("FAIL midrst_outputs: got busy=%0b done=%0b cs=%b id=%h want 0", busy, done, core_start, core_block_id); end
    cmp++; if (blocks_dispatched !== 8'd0 || blocks_completed !== 8'd0 || kernel_cycles !== 32'd0) begin
      errs++; $display("FAIL midrst_counters: got bd=%0d bc=%0d kc=%0d want 0", blocks_dispatched, blocks_completed, kernel_cycles); end
    core_done = 2'b11;
    tick();
    core_done = 2'b00;
    tick();
    cmp++; if (blocks_completed !== 8'd0 || core_start !== 2'b00 || busy !== 1'b0) begin
      errs++; $display("FAIL midrst_late_done: got bc=%0d cs=%b busy=%0b want 0", blocks_completed, core_start, busy); end
  endtask

`ifdef BLOCK_DISPATCH_RR_EN
  task automatic test_round_robin();
    logic [3:0] prev;
    int order[$];
    int fin;
    prev = '0;
    fin  = 0;
    for (int cyc = 0; cyc < 60 && fin == 0; cyc++) begin
      r_start     = (cyc == 0);
      r_num       = 8'd8;
      r_core_done = prev;
      if (r_done && cyc > 0) fin = 1;
      for (int c = 0; c < 4; c++) if (r_core_start[c]) order.push_back(c);
      prev = r_core_start;
      tick();
    end
    r_start     = 1'b0;
    r_core_done = '0;
    cmp++; if (order.size() != 8) begin errs++; $display("FAIL rr_count: got %0d want 8", order.size()); end
    for (int i = 0; i < 8 && i < order.size(); i++) begin
      cmp++; if (order[i] != i % 4) begin errs++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], i % 4); end
    end
    cmp++; if (r_bc !== 8'd8 || r_done !== 1'b1) begin errs++; $display("FAIL rr_end: got bc=%0d done=%0b want 8/1", r_bc, r_done); end
  endtask
`endif

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    num_blocks = '0;
    core_done  = '0;
`ifdef BLOCK_DISPATCH_RR_EN
    r_start     = 1'b0;
    r_num       = '0;
    r_core_done = '0;
`endif
    test_reset();
    test_five_blocks();
    test_zero_blocks();
    test_simultaneous_done();
    test_spurious_done();
    test_start_in_drain();
    test_reset_mid_kernel();
`ifdef BLOCK_DISPATCH_RR_EN
    test_round_robin();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
